// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg
// Shared encodings for the 6502 ALU front-end sequencer:
//   - ALU control codes of the shared 8-bit combinational ALU
//   - request op codes accepted on the req_* handshake
//   - sequencer FSM states
//   - {N,V,Z,C} flag bit positions and flag-mask constants
//   - operand / carry selector enums and the decoded-op struct
// ---------------------------------------------------------------------------
package alu_seq_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SR  = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100
  } alu_op_e;

  // Request op codes; 13..15 are undefined and reported as illegal.
  typedef enum logic [3:0] {
    OP_ADC = 4'd0,
    OP_SBC = 4'd1,
    OP_CMP = 4'd2,
    OP_AND = 4'd3,
    OP_ORA = 4'd4,
    OP_EOR = 4'd5,
    OP_BIT = 4'd6,
    OP_ASL = 4'd7,
    OP_LSR = 4'd8,
    OP_ROL = 4'd9,
    OP_ROR = 4'd10,
    OP_INC = 4'd11,
    OP_DEC = 4'd12
  } req_op_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EXEC   = 3'd1,
    S_FIX_LO = 3'd2,
    S_FIX_HI = 3'd3,
    S_RESP   = 3'd4
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  localparam logic [3:0] MASK_NVZC = 4'b1111;
  localparam logic [3:0] MASK_NZC  = 4'b1011;
  localparam logic [3:0] MASK_NZ   = 4'b1010;
  localparam logic [3:0] MASK_NVZ  = 4'b1110;
  localparam logic [3:0] MASK_NONE = 4'b0000;

  // Source of the ALU B operand during the EXEC pass.
  typedef enum logic [2:0] {
    BI_B,
    BI_NOT_B,
    BI_A,
    BI_ZERO,
    BI_ONE,
    BI_FF
  } bi_sel_e;

  // Source of the ALU carry-in during the EXEC pass.
  typedef enum logic [1:0] {
    CIN_ZERO,
    CIN_ONE,
    CIN_CARRY
  } cin_sel_e;

  typedef struct packed {
    alu_op_e    alu_op;
    bi_sel_e    bi_sel;
    cin_sel_e   cin_sel;
    logic [3:0] flag_mask;
    logic       write;
    logic       illegal;
  } decode_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_sequencer_if
// Bundles the request handshake, response handshake and the ALU drive/return
// bus of the sequencer.
//   slave  : the sequencer's view (accepts requests, drives the ALU)
//   master : the environment's view (decode/execute + the ALU itself)
// ---------------------------------------------------------------------------
interface alu_sequencer_if;
  import alu_seq_pkg::*;

  // request handshake
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_op;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic       req_carry;
  logic       req_decimal;

  // response handshake
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic [3:0] rsp_flags;
  logic [3:0] rsp_flag_mask;
  logic       rsp_write;
  logic       rsp_illegal;

  // ALU bus
  logic [2:0] alu_control;
  logic [7:0] alu_AI;
  logic [7:0] alu_BI;
  logic       alu_carry_in;
  logic [7:0] alu_Y;
  logic       alu_carry_out;
  logic       alu_overflow;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_carry, req_decimal,
    output req_ready,
    output rsp_valid, rsp_result, rsp_flags, rsp_flag_mask, rsp_write, rsp_illegal,
    input  rsp_ready,
    output alu_control, alu_AI, alu_BI, alu_carry_in,
    input  alu_Y, alu_carry_out, alu_overflow
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_carry, req_decimal,
    input  req_ready,
    input  rsp_valid, rsp_result, rsp_flags, rsp_flag_mask, rsp_write, rsp_illegal,
    output rsp_ready,
    input  alu_control, alu_AI, alu_BI, alu_carry_in,
    output alu_Y, alu_carry_out, alu_overflow
  );

endinterface

// File: rtl/alu_seq_decode.sv
// ---------------------------------------------------------------------------
// alu_seq_decode
// Combinational op decoder: maps a request op code to the ALU operation,
// B-operand source, carry-in source, flag mask and write-back enable.
//   op_i  : request op code
//   dec_o : decoded control bundle
// ---------------------------------------------------------------------------
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [3:0] op_i,
  output decode_t    dec_o
);

  always_comb begin
    // NOTE: the output gets a full default before the case so every path
    // assigns it; otherwise synthesis infers a latch.
    dec_o = '{ALU_ADD, BI_ZERO, CIN_ZERO, MASK_NONE, 1'b0, 1'b1};
    case (op_i)
      OP_ADC:  dec_o = '{ALU_ADD, BI_B,     CIN_CARRY, MASK_NVZC, 1'b1, 1'b0};
      OP_SBC:  dec_o = '{ALU_ADD, BI_NOT_B, CIN_CARRY, MASK_NVZC, 1'b1, 1'b0};
      OP_CMP:  dec_o = '{ALU_ADD, BI_NOT_B, CIN_ONE,   MASK_NZC,  1'b0, 1'b0};
      OP_AND:  dec_o = '{ALU_AND, BI_B,     CIN_ZERO,  MASK_NZ,   1'b1, 1'b0};
      OP_ORA:  dec_o = '{ALU_OR,  BI_B,     CIN_ZERO,  MASK_NZ,   1'b1, 1'b0};
      OP_EOR:  dec_o = '{ALU_XOR, BI_B,     CIN_ZERO,  MASK_NZ,   1'b1, 1'b0};
      OP_BIT:  dec_o = '{ALU_AND, BI_B,     CIN_ZERO,  MASK_NVZ,  1'b0, 1'b0};
      // Left shifts are a + a; ROL feeds the old carry into bit 0.
      OP_ASL:  dec_o = '{ALU_ADD, BI_A,     CIN_ZERO,  MASK_NZC,  1'b1, 1'b0};
      OP_ROL:  dec_o = '{ALU_ADD, BI_A,     CIN_CARRY, MASK_NZC,  1'b1, 1'b0};
      // Right shifts: the ALU shifts carry_in into bit 7.
      OP_LSR:  dec_o = '{ALU_SR,  BI_ZERO,  CIN_ZERO,  MASK_NZC,  1'b1, 1'b0};
      OP_ROR:  dec_o = '{ALU_SR,  BI_ZERO,  CIN_CARRY, MASK_NZC,  1'b1, 1'b0};
      OP_INC:  dec_o = '{ALU_ADD, BI_ONE,   CIN_ZERO,  MASK_NZ,   1'b1, 1'b0};
      OP_DEC:  dec_o = '{ALU_ADD, BI_FF,    CIN_ZERO,  MASK_NZ,   1'b1, 1'b0};
      default: dec_o = '{ALU_ADD, BI_ZERO,  CIN_ZERO,  MASK_NONE, 1'b0, 1'b1};
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
// Front-end controller for the shared 8-bit 6502 ALU. Accepts one request at
// a time, drives the ALU for one pass (binary) or three passes (BCD ADC/SBC),
// computes {N,V,Z,C} and returns the result over a valid/ready handshake.
//   clk   : system clock
//   reset : synchronous, active-high reset; aborts any operation in flight
//   bus   : request / response handshakes and the ALU bus (slave view)
// Parameter DECIMAL_EN: 1 enables BCD correction; 0 ignores req_decimal.
// ---------------------------------------------------------------------------
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter bit DECIMAL_EN = 1'b1
) (
  input logic            clk,
  input logic            reset,
  alu_sequencer_if.slave bus
);

  state_e     state_q, state_d;
  logic [3:0] op_q;
  logic [7:0] a_q, b_q;
  logic       carry_q;      // C flag captured with the request
  logic       decimal_q;    // D flag captured with the request (gated)
  logic [7:0] bin_q;        // binary result of the EXEC pass
  logic       bc_q;         // binary carry of the EXEC pass
  logic       bv_q;         // binary overflow of the EXEC pass
  logic [7:0] work_q;       // running result through the BCD fix passes
  logic       dcarry_q;     // decimal-mode C flag

  decode_t    dec;
  logic [7:0] bi_val;
  logic       cin_val;
  logic       is_adc, is_sbc, is_bit, decimal_op;
  logic       half_carry, lo_fix, hi_fix;
  logic [7:0] lo_add, hi_add;
  logic [3:0] raw_flags;

  alu_seq_decode u_decode (
    .op_i  (op_q),
    .dec_o (dec)
  );

  assign is_adc     = (op_q == OP_ADC);
  assign is_sbc     = (op_q == OP_SBC);
  assign is_bit     = (op_q == OP_BIT);
  assign decimal_op = decimal_q & (is_adc | is_sbc);

  always_comb begin
    bi_val = 8'h00;
    case (dec.bi_sel)
      BI_B:     bi_val = b_q;
      BI_NOT_B: bi_val = ~b_q;
      BI_A:     bi_val = a_q;
      BI_ONE:   bi_val = 8'h01;
      BI_FF:    bi_val = 8'hFF;
      default:  bi_val = 8'h00;
    endcase
  end

  always_comb begin
    cin_val = 1'b0;
    case (dec.cin_sel)
      CIN_ONE:   cin_val = 1'b1;
      CIN_CARRY: cin_val = carry_q;
      default:   cin_val = 1'b0;
    endcase
  end

  // Carry into bit 4 of the EXEC add, using the B operand the ALU actually
  // saw (b for ADC, ~b for SBC). bi_val is stable for the whole operation.
  assign half_carry = a_q[4] ^ bi_val[4] ^ bin_q[4];

  // ADC adds +6/+0x60 on a nibble overflow; SBC subtracts 6/0x60 (as +0xFA /
  // +0xA0) on a nibble borrow. A zero addend keeps the pass count fixed.
  assign lo_fix = is_adc ? ((bin_q[3:0] > 4'd9) | half_carry) : ~half_carry;
  assign hi_fix = is_adc ? ((work_q > 8'h99) | bc_q) : ~bc_q;
  assign lo_add = !lo_fix ? 8'h00 : (is_adc ? 8'h06 : 8'hFA);
  assign hi_add = !hi_fix ? 8'h00 : (is_adc ? 8'h60 : 8'hA0);

  // Next state, handshake and ALU drive.
  always_comb begin
    state_d          = state_q;
    bus.req_ready    = 1'b0;
    bus.rsp_valid    = 1'b0;
    bus.alu_control  = ALU_ADD;
    bus.alu_AI       = 8'h00;
    bus.alu_BI       = 8'h00;
    bus.alu_carry_in = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = S_EXEC;
      end
      S_EXEC: begin
        bus.alu_control  = dec.alu_op;
        bus.alu_AI       = a_q;
        bus.alu_BI       = bi_val;
        bus.alu_carry_in = cin_val;
        state_d          = decimal_op ? S_FIX_LO : S_RESP;
      end
      S_FIX_LO: begin
        bus.alu_AI = bin_q;
        bus.alu_BI = lo_add;
        state_d    = S_FIX_HI;
      end
      S_FIX_HI: begin
        bus.alu_AI = work_q;
        bus.alu_BI = hi_add;
        state_d    = S_RESP;
      end
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= 4'd0;
      a_q       <= 8'h00;
      b_q       <= 8'h00;
      carry_q   <= 1'b0;
      decimal_q <= 1'b0;
      bin_q     <= 8'h00;
      bc_q      <= 1'b0;
      bv_q      <= 1'b0;
      work_q    <= 8'h00;
      dcarry_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            op_q      <= bus.req_op;
            a_q       <= bus.req_a;
            b_q       <= bus.req_b;
            carry_q   <= bus.req_carry;
            decimal_q <= bus.req_decimal & DECIMAL_EN;
          end
        end
        S_EXEC: begin
          bin_q  <= bus.alu_Y;
          bc_q   <= bus.alu_carry_out;
          bv_q   <= bus.alu_overflow;
          work_q <= bus.alu_Y;
        end
        S_FIX_LO: work_q <= bus.alu_Y;
        S_FIX_HI: begin
          work_q   <= bus.alu_Y;
          dcarry_q <= is_adc ? hi_fix : bc_q;
        end
        default: ;
      endcase
    end
  end

  // Flags before masking. N and Z come from the binary result even in decimal
  // mode (NMOS behaviour); BIT takes N/V straight from the memory operand.
  always_comb begin
    raw_flags         = 4'b0000;
    raw_flags[FLAG_N] = is_bit ? b_q[7] : bin_q[7];
    raw_flags[FLAG_V] = is_bit ? b_q[6] : bv_q;
    raw_flags[FLAG_Z] = (bin_q == 8'h00);
    raw_flags[FLAG_C] = decimal_op ? dcarry_q : bc_q;
  end

  // Response fields are only driven while a response is offered, and are
  // purely a function of registers, so they hold until the handshake.
  always_comb begin
    bus.rsp_result    = 8'h00;
    bus.rsp_flags     = 4'b0000;
    bus.rsp_flag_mask = 4'b0000;
    bus.rsp_write     = 1'b0;
    bus.rsp_illegal   = 1'b0;
    if (state_q == S_RESP) begin
      bus.rsp_result    = dec.illegal ? a_q : work_q;
      bus.rsp_flags     = raw_flags & dec.flag_mask;
      bus.rsp_flag_mask = dec.flag_mask;
      bus.rsp_write     = dec.write;
      bus.rsp_illegal   = dec.illegal;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
// Directed bench for alu_sequencer with a behavioural model of the shared
// 8-bit ALU. Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   lat;

  always #5 clk = ~clk;

  alu_sequencer_if bus ();

  alu_sequencer #(.DECIMAL_EN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural ALU: ADD, SR (carry_in shifted into bit 7), AND, OR, XOR.
  logic [8:0] sum9;
  assign sum9 = {1'b0, bus.alu_AI} + {1'b0, bus.alu_BI} + {8'h00, bus.alu_carry_in};

  always_comb begin
    bus.alu_Y         = 8'h00;
    bus.alu_carry_out = 1'b0;
    bus.alu_overflow  = 1'b0;
    case (bus.alu_control)
      3'b000: begin
        bus.alu_Y         = sum9[7:0];
        bus.alu_carry_out = sum9[8];
        bus.alu_overflow  = (bus.alu_AI[7] == bus.alu_BI[7]) && (sum9[7] != bus.alu_AI[7]);
      end
      3'b001: begin
        bus.alu_Y         = {bus.alu_carry_in, bus.alu_AI[7:1]};
        bus.alu_carry_out = bus.alu_AI[0];
      end
      3'b010:  bus.alu_Y = bus.alu_AI & bus.alu_BI;
      3'b011:  bus.alu_Y = bus.alu_AI | bus.alu_BI;
      3'b100:  bus.alu_Y = bus.alu_AI ^ bus.alu_BI;
      default: bus.alu_Y = 8'h00;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; returns on the falling edge after the
  // accepting rising edge.
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic c, input logic d);
    bus.req_op      = op;
    bus.req_a       = a;
    bus.req_b       = b;
    bus.req_carry   = c;
    bus.req_decimal = d;
    bus.req_valid   = 1'b1;
    @(negedge clk);
    bus.req_valid   = 1'b0;
  endtask

  // Counts rising edges since the accept edge until rsp_valid is seen.
  task automatic wait_rsp(output int l);
    l = 1;
    while (!bus.rsp_valid && l < 20) begin
      @(negedge clk);
      l++;
    end
  endtask

  task automatic consume();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic check_rsp(input string tag, input logic [7:0] res, input logic [3:0] flags,
                           input logic [3:0] mask, input logic wr, input logic ill);
    check({tag, " result"},  bus.rsp_result,    res);
    check({tag, " flags"},   bus.rsp_flags,     flags);
    check({tag, " mask"},    bus.rsp_flag_mask, mask);
    check({tag, " write"},   bus.rsp_write,     wr);
    check({tag, " illegal"}, bus.rsp_illegal,   ill);
  endtask

  initial begin
    reset           = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_op      = 4'd0;
    bus.req_a       = 8'h00;
    bus.req_b       = 8'h00;
    bus.req_carry   = 1'b0;
    bus.req_decimal = 1'b0;
    bus.rsp_ready   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst req_ready", bus.req_ready, 1);
    check("rst rsp_valid", bus.rsp_valid, 0);
    check("rst rsp_result", bus.rsp_result, 8'h00);
    check("rst rsp_flags", bus.rsp_flags, 4'h0);
    check("rst alu_control", bus.alu_control, 3'b000);
    check("rst alu_AI", bus.alu_AI, 8'h00);

    // Binary ADC 0x50+0x50: overflow into sign, no carry
    send(4'd0, 8'h50, 8'h50, 1'b0, 1'b0);
    wait_rsp(lat);
    check("adc bin latency", lat, 2);
    check_rsp("adc bin", 8'hA0, 4'b1100, 4'b1111, 1'b1, 1'b0);
    consume();
    check("adc bin idle", bus.req_ready, 1);

    // Decimal ADC 58+46+1 = 105: result 0x05 carry 1; N,V from binary 0x9F
    send(4'd0, 8'h58, 8'h46, 1'b1, 1'b1);
    check("dadc exec BI", bus.alu_BI, 8'h46);
    check("dadc exec cin", bus.alu_carry_in, 1);
    @(negedge clk);
    check("dadc fixlo AI", bus.alu_AI, 8'h9F);
    check("dadc fixlo BI", bus.alu_BI, 8'h06);
    @(negedge clk);
    check("dadc fixhi AI", bus.alu_AI, 8'hA5);
    check("dadc fixhi BI", bus.alu_BI, 8'h60);
    @(negedge clk);
    check("dadc rsp_valid", bus.rsp_valid, 1);
    check_rsp("dadc", 8'h05, 4'b1101, 4'b1111, 1'b1, 1'b0);
    consume();

    // Decimal SBC 10-01 = 09, no borrow; both passes still taken
    send(4'd1, 8'h10, 8'h01, 1'b1, 1'b1);
    wait_rsp(lat);
    check("dsbc latency", lat, 4);
    check_rsp("dsbc", 8'h09, 4'b0001, 4'b1111, 1'b1, 1'b0);
    consume();

    // CMP equal: Z=1 C=1, no write-back
    send(4'd2, 8'h10, 8'h10, 1'b0, 1'b0);
    wait_rsp(lat);
    check("cmp latency", lat, 2);
    check_rsp("cmp", 8'h00, 4'b0011, 4'b1011, 1'b0, 1'b0);
    consume();

    // ROR 0x01 with C=1 -> 0x80, C=1, N=1
    send(4'd10, 8'h01, 8'h00, 1'b1, 1'b0);
    wait_rsp(lat);
    check_rsp("ror", 8'h80, 4'b1001, 4'b1011, 1'b1, 1'b0);
    consume();

    // BIT: N,V from operand b, Z from a&b
    send(4'd6, 8'h0F, 8'hC0, 1'b0, 1'b0);
    wait_rsp(lat);
    check("bit flags", bus.rsp_flags, 4'b1110);
    check("bit mask", bus.rsp_flag_mask, 4'b1110);
    check("bit write", bus.rsp_write, 0);
    consume();

    // INC wraps to zero, DEC wraps to 0xFF, ASL/LSR shift out into C
    send(4'd11, 8'hFF, 8'h00, 1'b1, 1'b0);
    wait_rsp(lat);
    check_rsp("inc", 8'h00, 4'b0010, 4'b1010, 1'b1, 1'b0);
    consume();
    send(4'd12, 8'h00, 8'h00, 1'b0, 1'b0);
    wait_rsp(lat);
    check_rsp("dec", 8'hFF, 4'b1000, 4'b1010, 1'b1, 1'b0);
    consume();
    send(4'd7, 8'h81, 8'h00, 1'b0, 1'b0);
    wait_rsp(lat);
    check_rsp("asl", 8'h02, 4'b0001, 4'b1011, 1'b1, 1'b0);
    consume();
    send(4'd8, 8'h01, 8'h00, 1'b1, 1'b0);
    wait_rsp(lat);
    check_rsp("lsr", 8'h00, 4'b0011, 4'b1011, 1'b1, 1'b0);
    consume();

    // Back-pressure: AND response held 5 cycles while the next request waits
    send(4'd3, 8'hF0, 8'h3C, 1'b0, 1'b0);
    wait_rsp(lat);
    bus.req_op    = 4'd5;
    bus.req_a     = 8'hFF;
    bus.req_b     = 8'h0F;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold rsp_valid", bus.rsp_valid, 1);
      check("hold req_ready", bus.req_ready, 0);
      check("hold result", bus.rsp_result, 8'h30);
      check("hold mask", bus.rsp_flag_mask, 4'b1010);
    end
    consume();
    check("post hs req_ready", bus.req_ready, 1);
    check("post hs rsp_valid", bus.rsp_valid, 0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("eor accepted", bus.req_ready, 0);
    wait_rsp(lat);
    check("eor latency", lat, 2);
    check_rsp("eor", 8'hF0, 4'b1000, 4'b1010, 1'b1, 1'b0);
    consume();

    // Reset in FIX_LO aborts with no response
    send(4'd0, 8'h58, 8'h46, 1'b1, 1'b1);
    @(negedge clk);
    check("abort in fixlo", bus.alu_BI, 8'h06);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort req_ready", bus.req_ready, 1);
    check("abort rsp_valid", bus.rsp_valid, 0);
    check("abort alu_BI", bus.alu_BI, 8'h00);
    repeat (3) begin
      @(negedge clk);
      check("abort no stale rsp", bus.rsp_valid, 0);
    end

    // Undefined op 14: passes a through, nothing written
    send(4'd14, 8'h3C, 8'h55, 1'b1, 1'b0);
    wait_rsp(lat);
    check("illegal latency", lat, 2);
    check_rsp("illegal", 8'h3C, 4'b0000, 4'b0000, 1'b0, 1'b1);
    consume();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Front-end controller for the shared 8-bit combinational ALU (ops ADD, SR, AND, OR, XOR).
- Accepts one 6502 arithmetic/logic request at a time over a valid/ready handshake and drives the ALU control and operand inputs across one pass, or three passes for decimal mode.
- Computes N/V/Z/C and returns the result over a second valid/ready handshake.
- Sits between instruction decode/execute and the ALU; it is the only block that drives ALU inputs.

Parameters:
- DECIMAL_EN, 1, enables BCD correction for ADC/SBC; when 0 the req_decimal input is ignored.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_op  in  4  operation code (see package)
- req_a  in  8  operand A (accumulator/memory for shifts, INC, DEC)
- req_b  in  8  operand B
- req_carry  in  1  current C flag
- req_decimal  in  1  current D flag
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_result  out  8  result byte
- rsp_flags  out  4  {N,V,Z,C}
- rsp_flag_mask  out  4  flags the consumer must write, in {N,V,Z,C} order
- rsp_write  out  1  result must be written back (0 for CMP and BIT)
- rsp_illegal  out  1  undefined op code
- alu_control  out  3  to ALU
- alu_AI  out  8  to ALU
- alu_BI  out  8  to ALU
- alu_carry_in  out  1  to ALU
- alu_Y  in  8  from ALU
- alu_carry_out  in  1  from ALU
- alu_overflow  in  1  from ALU

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state = IDLE, rsp_valid = 0, req_ready = 1, all rsp_* outputs = 0, ALU outputs = 0.
- A reset asserted in any state aborts the operation in flight, with no response.
- FSM states: IDLE, EXEC, FIX_LO, FIX_HI, RESP.
- IDLE:
  - A request is accepted when req_valid & req_ready.
  - On accept, register op, a, b, carry, decimal, then go to EXEC.
- EXEC:
  - Drive the ALU per op and register alu_Y, alu_carry_out, alu_overflow.
  - Go to FIX_LO for ADC/SBC with decimal & DECIMAL_EN; otherwise go to RESP.
- RESP:
  - rsp_valid = 1. All rsp_* outputs are held stable until rsp_ready.
  - On rsp_ready, go to IDLE. req_ready rises the next cycle, so there is no back-to-back accept.
- Latency from accept edge to rsp_valid: 2 cycles binary, 4 cycles decimal. Decimal latency is fixed and does not depend on the data.
- Op mapping (ALU op, BI, carry_in):
  - ADC: ADD, b, c.
  - SBC: ADD, ~b, c.
  - CMP: ADD, ~b, 1.
  - AND: AND.
  - ORA: OR.
  - EOR: XOR.
  - BIT: AND.
  - ASL: ADD, a, 0.
  - ROL: ADD, a, c.
  - LSR: SR, carry_in 0.
  - ROR: SR, carry_in c.
  - INC: ADD, 0x01, 0.
  - DEC: ADD, 0xFF, 0.
- Flags:
  - N = result[7]; Z = (result == 0).
  - C = alu_carry_out for ADC/SBC/CMP/shifts.
  - V = alu_overflow for ADC/SBC.
  - BIT: N = b[7], V = b[6], Z from the AND result.
- Flag masks:
  - ADC/SBC = 1111.
  - CMP = 1011.
  - shifts = 1011.
  - AND/ORA/EOR/INC/DEC = 1010.
  - BIT = 1110.
- Decimal ADC:
  - Half-carry h = (a ^ b ^ bin)[4].
  - FIX_LO adds 0x06 when bin[3:0] > 9 or h.
  - FIX_HI adds 0x60 when the result after FIX_LO exceeds 0x99 or the binary carry was set; C is 1 in that case.
  - When no fix applies, the ALU adds 0x00, so every decimal op takes both passes.
- Decimal SBC:
  - FIX_LO adds 0xFA when h = 0.
  - FIX_HI adds 0xA0 when the binary carry = 0.
  - C = binary carry.
- Decimal N, V and Z are taken from the binary EXEC result (NMOS behaviour). C is taken as defined above.
- Undefined op: result = a, mask = 0000, rsp_write = 0, rsp_illegal = 1, normal 2-cycle latency.
- ALU outputs are 0 (control = ADD) in IDLE and RESP.

Decomposition:
- Package alu_seq_pkg contains:
  - ALU op encodings: ADD 000, SR 001, AND 010, OR 011, XOR 100.
  - req_op encodings: ADC 0, SBC 1, CMP 2, AND 3, ORA 4, EOR 5, BIT 6, ASL 7, LSR 8, ROL 9, ROR 10, INC 11, DEC 12; codes 13–15 are illegal.
  - FSM state encodings.
  - Flag bit indices N = 3, V = 2, Z = 1, C = 0.
- One natural sub-module: alu_seq_decode. It is combinational and maps op to {alu op, BI select, carry select, flag mask, write}.

Test Plan:
- ADC a=0x50 b=0x50 c=0 d=0 -> rsp_valid 2 cycles after accept; result 0x A0; flags N=1 V=1 Z=0 C=0; mask 1111.
- ADC a=0x58 b=0x46 c=1 d=1 -> result 0x05, C=1; 4-cycle latency; ALU sees 0x06 then 0x60 in the fix passes.
- CMP a=0x10 b=0x10 -> result discarded (rsp_write 0); Z=1 C=1 N=0; mask 1011. Then ROR a=0x01 c=1 -> result 0x80, C=1, N=1.
- Hold rsp_ready low 5 cycles -> rsp_* stable and req_ready = 0 throughout; req_valid held high is accepted only the cycle after the handshake.
- Assert reset during FIX_LO -> next cycle state IDLE, rsp_valid 0, req_ready 1; no stale response.
- req_op = 14 a=0x3C -> rsp_illegal 1, result 0x3C, mask 0000.
